// File: rtl/adc0809_if.sv
// adc0809_if: pin bundle between an ADC0809 controller and the converter.
//   ch_in[63:0]   eight 8-bit channel values, channel k at [8k+7:8k]
//   addr[2:0]     channel select
//   ale           address latch enable
//   start         conversion start (rise = reset SAR, fall = begin)
//   oe            output enable
//   eoc           end of conversion (1 = idle/complete)
//   data[7:0]     conversion result while oe is high
//   data_oe       tristate enable for a pad wrapper
//   proto_err     sticky protocol error
//   conv_cnt      completed conversion count
// master = controller side, slave = converter side.
interface adc0809_if;
  logic [63:0] ch_in;
  logic [2:0]  addr;
  logic        ale;
  logic        start;
  logic        oe;
  logic        eoc;
  logic [7:0]  data;
  logic        data_oe;
  logic        proto_err;
  logic [15:0] conv_cnt;

  modport master (
    output ch_in, addr, ale, start, oe,
    input  eoc, data, data_oe, proto_err, conv_cnt
  );

  modport slave (
    input  ch_in, addr, ale, start, oe,
    output eoc, data, data_oe, proto_err, conv_cnt
  );
endinterface

// File: rtl/adc0809_model.sv
// adc0809_model: synchronous responder model of an ADC0809 converter.
// Latches the channel address on ale, runs an 8-step successive
// approximation on the selected channel value after start, drops eoc
// during conversion and presents the result while oe is high.
// Ports:
//   clk  model clock, also the converter clock
//   rst  synchronous reset, active-high
//   bus  adc0809_if.slave (ch_in, addr, ale, start, oe -> eoc, data,
//        data_oe, proto_err, conv_cnt)
// Parameters:
//   CLKS_PER_BIT  clk cycles per SAR bit decision (1..255)
//   EOC_DELAY     clk cycles from start-fall detection to eoc falling (1..255)
module adc0809_model #(
  parameter int CLKS_PER_BIT = 8,
  parameter int EOC_DELAY    = 8
) (
  input logic      clk,
  input logic      rst,
  adc0809_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ARMED, EOC_WAIT, CONVERT} state_t;

  localparam logic [7:0] BIT_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] DLY_LAST = 8'(EOC_DELAY - 1);

  // One SAR decision: keep the trial bit only if it does not overshoot.
  function automatic logic [7:0] sar_step(input logic [7:0] sar_in,
                                          input logic [2:0] bit_in,
                                          input logic [7:0] samp_in);
    logic [7:0] trial;
    trial = sar_in | (8'd1 << bit_in);
    return (trial <= samp_in) ? trial : sar_in;
  endfunction

  // Stage p0: registered pins for edge detection
  logic ale_p0, start_p0, oe_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ale_p0   <= 1'b0;
      start_p0 <= 1'b0;
      oe_p0    <= 1'b0;
    end else begin
      ale_p0   <= bus.ale;
      start_p0 <= bus.start;
      oe_p0    <= bus.oe;
    end
  end

  logic ale_rise, start_rise, start_fall;
  assign ale_rise   =  bus.ale   & ~ale_p0;
  assign start_rise =  bus.start & ~start_p0;
  assign start_fall = ~bus.start &  start_p0;

  // Channel select follows ale in every state; CONVERT works from samp,
  // so relatching mid-conversion cannot disturb the running result.
  logic [2:0] ch_sel;

  always_ff @(posedge clk) begin
    if (rst)           ch_sel <= 3'd0;
    else if (ale_rise) ch_sel <= bus.addr;
  end

  state_t      state, state_n;
  logic [7:0]  samp, samp_n;
  logic [7:0]  sar, sar_n;
  logic [7:0]  result, result_n;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic        eoc, eoc_n;
  logic        perr, perr_n;
  logic [15:0] conv_cnt, conv_cnt_n;
  logic [7:0]  sar_dec;

  assign sar_dec = sar_step(sar, bit_idx, samp);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      samp     <= 8'h00;
      sar      <= 8'h00;
      result   <= 8'h00;
      cnt      <= 8'd0;
      bit_idx  <= 3'd7;
      eoc      <= 1'b1;
      perr     <= 1'b0;
      conv_cnt <= 16'd0;
    end else begin
      state    <= state_n;
      samp     <= samp_n;
      sar      <= sar_n;
      result   <= result_n;
      cnt      <= cnt_n;
      bit_idx  <= bit_n;
      eoc      <= eoc_n;
      perr     <= perr_n;
      conv_cnt <= conv_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    samp_n     = samp;
    sar_n      = sar;
    result_n   = result;
    cnt_n      = cnt;
    bit_n      = bit_idx;
    eoc_n      = eoc;
    perr_n     = perr;
    conv_cnt_n = conv_cnt;

    // Reading while a conversion is in flight is a controller bug.
    if (oe_p0 && !eoc) perr_n = 1'b1;

    case (state)
      IDLE: begin
        if (start_rise) begin
          state_n = ARMED;
          sar_n   = 8'h00;
        end
      end
      ARMED: begin
        if (start_fall) begin
          state_n = EOC_WAIT;
          cnt_n   = 8'd0;
        end
      end
      EOC_WAIT: begin
        if (start_rise) begin
          state_n = ARMED;
          sar_n   = 8'h00;
          eoc_n   = 1'b1;
          perr_n  = 1'b1;
        end else if (cnt == DLY_LAST) begin
          state_n = CONVERT;
          eoc_n   = 1'b0;
          samp_n  = bus.ch_in[{ch_sel, 3'b000} +: 8];
          bit_n   = 3'd7;
          cnt_n   = 8'd0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      CONVERT: begin
        if (start_rise) begin
          state_n = ARMED;
          sar_n   = 8'h00;
          eoc_n   = 1'b1;
          perr_n  = 1'b1;
        end else if (cnt == BIT_LAST) begin
          cnt_n = 8'd0;
          sar_n = sar_dec;
          if (bit_idx == 3'd0) begin
            state_n    = IDLE;
            result_n   = sar_dec;
            eoc_n      = 1'b1;
            conv_cnt_n = conv_cnt + 16'd1;
          end else begin
            bit_n = bit_idx - 3'd1;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Stage p1: registered output path, two cycles behind the oe pin
  logic [7:0] data_p1;
  logic       data_oe_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1    <= 8'h00;
      data_oe_p1 <= 1'b0;
    end else begin
      data_p1    <= oe_p0 ? result : 8'h00;
      data_oe_p1 <= oe_p0;
    end
  end

  assign bus.eoc       = eoc;
  assign bus.data      = data_p1;
  assign bus.data_oe   = data_oe_p1;
  assign bus.proto_err = perr;
  assign bus.conv_cnt  = conv_cnt;

endmodule

// File: tb/tb_adc0809_model.sv
// tb_adc0809_model: scoreboard bench for adc0809_model.
// Two instances: dut0 at default timing (8/8) and dut1 at CLKS_PER_BIT=1,
// EOC_DELAY=1. Stimulus pushes expected completions and read-outs into
// per-instance queues; a monitor pops them on eoc and data_oe rises.
`timescale 1ns/1ps
module tb_adc0809_model;

  localparam int D0 = 8, C0 = 8, D1 = 1, C1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] ch_in   = '0;
  logic [2:0]  addr    = 3'd0;
  logic        ale     = 1'b0;
  logic [1:0]  start_r = 2'b00;
  logic [1:0]  oe_r    = 2'b00;

  adc0809_if bus0();
  adc0809_if bus1();

  assign bus0.ch_in = ch_in;
  assign bus0.addr  = addr;
  assign bus0.ale   = ale;
  assign bus0.start = start_r[0];
  assign bus0.oe    = oe_r[0];
  assign bus1.ch_in = ch_in;
  assign bus1.addr  = addr;
  assign bus1.ale   = ale;
  assign bus1.start = start_r[1];
  assign bus1.oe    = oe_r[1];

  adc0809_model #(.CLKS_PER_BIT(C0), .EOC_DELAY(D0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  adc0809_model #(.CLKS_PER_BIT(C1), .EOC_DELAY(D1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [1:0]  eoc_s, doe_s, perr_s;
  logic [7:0]  data_s [2];
  logic [15:0] cnt_s  [2];
  assign eoc_s     = {bus1.eoc, bus0.eoc};
  assign doe_s     = {bus1.data_oe, bus0.data_oe};
  assign perr_s    = {bus1.proto_err, bus0.proto_err};
  assign data_s[0] = bus0.data;
  assign data_s[1] = bus1.data;
  assign cnt_s[0]  = bus0.conv_cnt;
  assign cnt_s[1]  = bus1.conv_cnt;

  // kind: 0 = completes normally, 1 = aborted by a new start, 2 = killed by rst
  typedef struct {
    int          kind;
    int          fall_cyc;
    logic [15:0] cnt;
  } rec_t;

  rec_t       exp_q [2][$];
  logic [7:0] exp_d [2][$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model state
  logic [2:0]  sel_m = 3'd0;
  logic [7:0]  res_m  [2] = '{8'h00, 8'h00};
  logic [7:0]  pend_v [2] = '{8'h00, 8'h00};
  logic [15:0] cnt_m  [2] = '{16'd0, 16'd0};
  logic        perr_m [2] = '{1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int dly(input int k);
    return (k == 0) ? D0 : D1;
  endfunction

  function automatic int cpb(input int k);
    return (k == 0) ? C0 : C1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    vectors++;
    miscompares++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Monitor: eoc rises retire conversions, data_oe rises retire read-outs.
  initial begin : monitor
    logic [1:0] eoc_prev;
    logic [1:0] doe_prev;
    int         fall_obs [2];
    rec_t       r;
    eoc_prev = 2'b11;
    doe_prev = 2'b00;
    fall_obs = '{0, 0};
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (eoc_s[k] === 1'b0 && eoc_prev[k] === 1'b1) fall_obs[k] = cyc;
        if (eoc_s[k] === 1'b1 && eoc_prev[k] === 1'b0) begin
          if (exp_q[k].size() == 0) begin
            fail_now($sformatf("dut%0d eoc_rise", k), "unexpected eoc rise");
          end else begin
            r = exp_q[k].pop_front();
            chk($sformatf("dut%0d eoc_fall_lat", k), fall_obs[k] - r.fall_cyc, dly(k));
            if (r.kind == 0)
              chk($sformatf("dut%0d eoc_rise_lat", k), cyc - r.fall_cyc, dly(k) + 8 * cpb(k));
            chk($sformatf("dut%0d conv_cnt", k), cnt_s[k], r.cnt);
          end
        end
        if (doe_s[k] === 1'b1 && doe_prev[k] === 1'b0) begin
          if (exp_d[k].size() == 0) fail_now($sformatf("dut%0d data_oe", k), "unexpected data_oe rise");
          else chk($sformatf("dut%0d data", k), data_s[k], exp_d[k].pop_front());
        end
        eoc_prev[k] = eoc_s[k];
        doe_prev[k] = doe_s[k];
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic set_ch(input int c, input logic [7:0] v);
    ch_in[8*c +: 8] = v;
  endtask

  task automatic latch(input logic [2:0] a);
    @(negedge clk);
    addr = a;
    ale  = 1'b1;
    @(negedge clk);
    ale   = 1'b0;
    sel_m = a;
  endtask

  task automatic start_conv(input int k, input int kind);
    rec_t r;
    pend_v[k] = ch_in[8*sel_m +: 8];
    @(negedge clk);
    start_r[k] = 1'b1;
    repeat (2) @(negedge clk);
    start_r[k] = 1'b0;
    r.kind     = kind;
    r.fall_cyc = cyc + 1;
    r.cnt      = (kind == 0) ? cnt_m[k] + 16'd1 : ((kind == 2) ? 16'd0 : cnt_m[k]);
    exp_q[k].push_back(r);
  endtask

  task automatic wait_empty(input int k);
    int n = 0;
    while (exp_q[k].size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[k].size() != 0) begin
      fail_now($sformatf("dut%0d eoc_timeout", k), "eoc did not return within 2000 cycles");
      exp_q[k].delete();
    end
  endtask

  task automatic finish_conv(input int k);
    wait_empty(k);
    res_m[k] = pend_v[k];
    cnt_m[k] = cnt_m[k] + 16'd1;
  endtask

  task automatic read_out(input int k);
    @(negedge clk);
    oe_r[k] = 1'b1;
    exp_d[k].push_back(res_m[k]);
    if (eoc_s[k] !== 1'b1) perr_m[k] = 1'b1;
    repeat (4) @(negedge clk);
    oe_r[k] = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_d[k].size() != 0) begin
      fail_now($sformatf("dut%0d read_timeout", k), "data_oe never rose");
      exp_d[k].delete();
    end
    chk($sformatf("dut%0d data_idle", k), data_s[k], 8'h00);
    chk($sformatf("dut%0d data_oe_idle", k), doe_s[k], 1'b0);
  endtask

  task automatic convert_read(input int k);
    start_conv(k, 0);
    finish_conv(k);
    read_out(k);
  endtask

  task automatic check_reset_state(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s dut%0d eoc", tag, k), eoc_s[k], 1'b1);
      chk($sformatf("%s dut%0d data", tag, k), data_s[k], 8'h00);
      chk($sformatf("%s dut%0d data_oe", tag, k), doe_s[k], 1'b0);
      chk($sformatf("%s dut%0d proto_err", tag, k), perr_s[k], 1'b0);
      chk($sformatf("%s dut%0d conv_cnt", tag, k), cnt_s[k], 16'd0);
    end
  endtask

  initial begin : stimulus
    logic [2:0] a;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Basic conversion of channel 3
    set_ch(3, 8'hA5);
    latch(3'd3);
    convert_read(0);
    chk("basic proto_err", perr_s[0], 1'b0);

    // Code boundaries
    set_ch(0, 8'h00); latch(3'd0); convert_read(0);
    set_ch(7, 8'hFF); latch(3'd7); convert_read(0);
    set_ch(5, 8'h80); latch(3'd5); convert_read(0);
    set_ch(5, 8'h7F); convert_read(0);

    // Address only changes on ale
    set_ch(2, 8'h3C);
    set_ch(6, 8'hC3);
    latch(3'd2);
    @(negedge clk);
    addr = 3'd6;
    start_conv(0, 0);
    repeat (D0 + 10) @(negedge clk);
    latch(3'd6);
    finish_conv(0);
    read_out(0);
    convert_read(0);

    // oe during conversion, then rst mid-conversion
    set_ch(4, 8'h11);
    latch(3'd4);
    convert_read(0);
    chk("pre_oe proto_err", perr_s[0], 1'b0);
    start_conv(0, 2);
    repeat (D0 + 5) @(negedge clk);
    read_out(0);
    chk("oe_busy proto_err", perr_s[0], perr_m[0]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst");
    rst = 1'b0;
    sel_m  = 3'd0;
    res_m  = '{8'h00, 8'h00};
    cnt_m  = '{16'd0, 16'd0};
    perr_m = '{1'b0, 1'b0};
    if (exp_q[0].size() != 0) begin
      fail_now("mid_rst eoc", "reset did not retire the running conversion");
      exp_q[0].delete();
    end

    // Restart 20 cycles into CONVERT
    set_ch(1, 8'h5A);
    latch(3'd1);
    convert_read(0);
    start_conv(0, 1);
    repeat (D0 + 20) @(negedge clk);
    start_r[0] = 1'b1;
    wait_empty(0);
    perr_m[0] = 1'b1;
    chk("abort proto_err", perr_s[0], perr_m[0]);
    chk("abort conv_cnt", cnt_s[0], cnt_m[0]);
    start_conv(0, 0);
    finish_conv(0);
    read_out(0);

    // Fast instance
    set_ch(4, 8'h96);
    latch(3'd4);
    convert_read(1);

    // Random channel contents and addresses on both instances
    for (int i = 0; i < 8; i++) begin
      ch_in = {$urandom, $urandom};
      a = 3'($urandom_range(0, 7));
      latch(a);
      convert_read(i % 2);
    end

    chk("final dut0 conv_cnt", cnt_s[0], cnt_m[0]);
    chk("final dut1 conv_cnt", cnt_s[1], cnt_m[1]);
    chk("final dut0 proto_err", perr_s[0], perr_m[0]);
    chk("final dut1 proto_err", perr_s[1], perr_m[1]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
